// File: rtl/button_event_decoder_pkg.sv
// button_event_decoder_pkg: shared FSM state encoding, default timing constants
// and a width helper for the button event decoder.
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        ARM       = 3'd0,
        IDLE      = 3'd1,
        DOWN1     = 3'd2,
        WAIT_GAP  = 3'd3,
        DOWN2     = 3'd4,
        LONG_HOLD = 3'd5
    } state_t;

    localparam int DEF_TICK_DIV     = 100000;
    localparam int DEF_LONG_TICKS   = 800;
    localparam int DEF_GAP_TICKS    = 250;
    localparam int DEF_REPEAT_TICKS = 100;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// button_event_decoder_if: button level in, classified event pulses out.
//   btn_in        debounced button level, 1 = pressed (may be asynchronous)
//   press         1-cycle pulse on synchronized rising edge
//   released      1-cycle pulse on synchronized falling edge
//   click         1-cycle pulse: single short press, gap expired
//   double_click  1-cycle pulse: second press within the gap
//   long_press    1-cycle pulse: held for LONG_TICKS
//   repeat_evt    1-cycle pulse every REPEAT_TICKS after long_press
//   held          registered synchronized button level
// master drives btn_in, slave (the decoder) drives the events.
interface button_event_decoder_if;
    logic btn_in;
    logic press;
    logic released;
    logic click;
    logic double_click;
    logic long_press;
    logic repeat_evt;
    logic held;

    modport master (
        output btn_in,
        input  press, released, click, double_click, long_press, repeat_evt, held
    );

    modport slave (
        input  btn_in,
        output press, released, click, double_click, long_press, repeat_evt, held
    );
endinterface

// File: rtl/button_event_decoder_tick_prescaler.sv
// button_event_decoder_tick_prescaler: free-running 0..DIV-1 counter whose
// wrap is the timebase tick.
//   clk   in  clock
//   rst   in  asynchronous reset, active-high
//   clr   in  restart the count from 0 on the next edge
//   tick  out high in the last cycle of each DIV-cycle period
module button_event_decoder_tick_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int PW = $clog2(DIV) + 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = cnt == LAST;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else
            cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies a debounced button level into press,
// release, click, double-click, long-press and auto-repeat pulses.
//   clk  in  system clock
//   rst  in  asynchronous reset, active-high
//   bus  slave side of button_event_decoder_if (btn_in in, event pulses
//        and held level out, all outputs registered)
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int LONG_TICKS   = DEF_LONG_TICKS,
    parameter int GAP_TICKS    = DEF_GAP_TICKS,
    parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
    input logic                   clk,
    input logic                   rst,
    button_event_decoder_if.slave bus
);
    localparam int CW = $clog2(max3(LONG_TICKS, GAP_TICKS, REPEAT_TICKS)) + 1;
    localparam logic [CW-1:0] CMAX = '1;

    state_t        state;
    logic          s1, s2, lvl, prev;
    logic [2:0]    fill;
    logic [CW-1:0] cnt;
    logic          tick, rise, fall, done_long, done_gap, done_rep, restart;

    assign bus.held = lvl;

    button_event_decoder_tick_prescaler #(.DIV(TICK_DIV)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .tick (tick)
    );

    // restart marks every state change (and each repeat reload) so the
    // prescaler and tick counter start from zero on the entering edge.
    always_comb begin
        rise      = lvl & ~prev;
        fall      = ~lvl & prev;
        done_long = tick && cnt == CW'(LONG_TICKS - 1);
        done_gap  = tick && cnt == CW'(GAP_TICKS - 1);
        done_rep  = (REPEAT_TICKS != 0) && tick && cnt == CW'(REPEAT_TICKS - 1);
        restart   = 1'b0;
        case (state)
            ARM:       restart = fill[2] & ~lvl;
            IDLE:      restart = rise;
            DOWN1:     restart = fall | done_long;
            WAIT_GAP:  restart = rise | done_gap;
            DOWN2:     restart = fall;
            LONG_HOLD: restart = fall | done_rep;
            default:   restart = 1'b1;
        endcase
    end

    // fill tracks when lvl holds a real sample after reset; until then the
    // cleared synchronizer would look like a released button and let ARM
    // through while the button is still held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1, s2, lvl, prev} <= '0;
            fill                <= '0;
            cnt                 <= '0;
            state               <= ARM;
            bus.press           <= 1'b0;
            bus.released        <= 1'b0;
            bus.click           <= 1'b0;
            bus.double_click    <= 1'b0;
            bus.long_press      <= 1'b0;
            bus.repeat_evt      <= 1'b0;
        end else begin
            s1               <= bus.btn_in;
            s2               <= s1;
            lvl              <= s2;
            prev             <= lvl;
            fill             <= {fill[1:0], 1'b1};
            cnt              <= restart ? '0 : (tick && cnt != CMAX) ? cnt + 1'b1 : cnt;
            bus.press        <= rise && state != ARM;
            bus.released     <= fall && state != ARM;
            // edges win over timeouts landing in the same cycle
            bus.click        <= state == WAIT_GAP && !rise && done_gap;
            bus.double_click <= state == WAIT_GAP && rise;
            bus.long_press   <= state == DOWN1 && !fall && done_long;
            bus.repeat_evt   <= state == LONG_HOLD && !fall && done_rep;
            case (state)
                ARM:       if (fill[2] && !lvl) state <= IDLE;
                IDLE:      if (rise) state <= DOWN1;
                DOWN1:     if (fall) state <= WAIT_GAP; else if (done_long) state <= LONG_HOLD;
                WAIT_GAP:  if (rise) state <= DOWN2; else if (done_gap) state <= IDLE;
                DOWN2:     if (fall) state <= IDLE;
                LONG_HOLD: if (fall) state <= IDLE;
                default:   state <= ARM;
            endcase
        end
    end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: table-driven and hand-sequenced checks of the
// button event decoder with a cycle-stamped expected-event scoreboard.
module tb_button_event_decoder;

    typedef enum int {EV_PRESS, EV_RELEASE, EV_CLICK, EV_DOUBLE, EV_LONG, EV_REPEAT} ev_t;

    typedef struct {
        int  at;
        ev_t kind;
    } exp_t;

    // stimulus: hi1 high, lo1 low, optional hi2 high then low;
    // expected event cycles are offsets from the first rising drive, -1 = none
    typedef struct {
        int hi1, lo1, hi2;
        int press1, rel1, click1, dbl, lng, rep1, rep2, press2, rel2, click2;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0;
    exp_t sb[$];
    vec_t vecs[11];

    button_event_decoder_if bus();

    button_event_decoder #(
        .TICK_DIV     (10),
        .LONG_TICKS   (8),
        .GAP_TICKS    (5),
        .REPEAT_TICKS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, got, req);
        end
    endtask

    task automatic check_ev(input logic v, input ev_t k);
        int idx;
        idx = -1;
        if (v === 1'b1) begin
            foreach (sb[i]) if (idx < 0 && sb[i].at == cyc && sb[i].kind == k) idx = i;
            checks++;
            if (idx < 0) begin
                failures++;
                $display("FAIL unexpected %s at cycle %0d: got 1, required 0", k.name(), cyc);
            end else
                sb.delete(idx);
        end
    endtask

    task automatic push(input int base, input int off, input ev_t k);
        if (off >= 0) sb.push_back('{base + off, k});
    endtask

    always @(negedge clk) begin
        check_ev(bus.press, EV_PRESS);
        check_ev(bus.released, EV_RELEASE);
        check_ev(bus.click, EV_CLICK);
        check_ev(bus.double_click, EV_DOUBLE);
        check_ev(bus.long_press, EV_LONG);
        check_ev(bus.repeat_evt, EV_REPEAT);
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].at < cyc) begin
                checks++;
                failures++;
                $display("FAIL missed %s: required at cycle %0d, got none by %0d", sb[i].kind.name(), sb[i].at, cyc);
                sb.delete(i);
            end
    end

    task automatic check_all_low(input string tag);
        chk({tag, "_press"}, bus.press, 0);
        chk({tag, "_release"}, bus.released, 0);
        chk({tag, "_click"}, bus.click, 0);
        chk({tag, "_double"}, bus.double_click, 0);
        chk({tag, "_long"}, bus.long_press, 0);
        chk({tag, "_repeat"}, bus.repeat_evt, 0);
        chk({tag, "_held"}, bus.held, 0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        @(negedge clk);
        bus.btn_in = 1'b1;
        t0 = cyc;
        push(t0, v.press1, EV_PRESS);
        push(t0, v.rel1, EV_RELEASE);
        push(t0, v.click1, EV_CLICK);
        push(t0, v.dbl, EV_DOUBLE);
        push(t0, v.lng, EV_LONG);
        push(t0, v.rep1, EV_REPEAT);
        push(t0, v.rep2, EV_REPEAT);
        push(t0, v.press2, EV_PRESS);
        push(t0, v.rel2, EV_RELEASE);
        push(t0, v.click2, EV_CLICK);
        repeat (v.hi1) @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (v.lo1) @(negedge clk);
        if (v.hi2 > 0) begin
            bus.btn_in = 1'b1;
            repeat (v.hi2) @(negedge clk);
            bus.btn_in = 1'b0;
        end
        repeat (120) @(negedge clk);
        chk($sformatf("vec%0d_drain", n), sb.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{30, 100, 0,   4, 34, 84, -1, -1, -1, -1, -1, -1, -1};
        vecs[1]  = '{30, 20, 30,   4, 34, -1, 54, -1, -1, -1, 54, 84, -1};
        vecs[2]  = '{150, 100, 0,  4, 154, -1, -1, 84, 114, 144, -1, -1, -1};
        vecs[3]  = '{80, 100, 0,   4, 84, 134, -1, -1, -1, -1, -1, -1, -1};
        vecs[4]  = '{81, 100, 0,   4, 85, -1, -1, 84, -1, -1, -1, -1, -1};
        vecs[5]  = '{79, 100, 0,   4, 83, 133, -1, -1, -1, -1, -1, -1, -1};
        vecs[6]  = '{30, 50, 20,   4, 34, -1, 84, -1, -1, -1, 84, 104, -1};
        vecs[7]  = '{30, 51, 20,   4, 34, 84, -1, -1, -1, -1, 85, 105, 155};
        vecs[8]  = '{110, 100, 0,  4, 114, -1, -1, 84, -1, -1, -1, -1, -1};
        vecs[9]  = '{111, 100, 0,  4, 115, -1, -1, 84, 114, -1, -1, -1, -1};
        vecs[10] = '{30, 20, 150,  4, 34, -1, 54, -1, -1, -1, 54, 204, -1};

        // button held through reset: no events until it has been released
        rst = 1'b1;
        bus.btn_in = 1'b1;
        repeat (3) @(negedge clk);
        check_all_low("reset");
        rst = 1'b0;
        repeat (200) @(negedge clk);
        chk("arm_held", bus.held, 1);
        bus.btn_in = 1'b0;
        repeat (20) @(negedge clk);
        chk("arm_released_held", bus.held, 0);

        // first real press: held after 3 edges, press after 4
        @(negedge clk);
        bus.btn_in = 1'b1;
        t0 = cyc;
        push(t0, 4, EV_PRESS);
        repeat (2) @(negedge clk);
        chk("held_lag2", bus.held, 0);
        @(negedge clk);
        chk("held_lag3", bus.held, 1);
        repeat (27) @(negedge clk);
        bus.btn_in = 1'b0;
        push(t0, 34, EV_RELEASE);
        push(t0, 84, EV_CLICK);
        repeat (120) @(negedge clk);
        chk("first_drain", sb.size(), 0);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // reset in LONG_HOLD, landing in a repeat cycle
        @(negedge clk);
        bus.btn_in = 1'b1;
        t0 = cyc;
        push(t0, 4, EV_PRESS);
        push(t0, 84, EV_LONG);
        push(t0, 114, EV_REPEAT);
        repeat (114) @(negedge clk);
        chk("pre_rst_repeat", bus.repeat_evt, 1);
        chk("pre_rst_held", bus.held, 1);
        #1 rst = 1'b1;
        #1;
        check_all_low("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("rearm_held", bus.held, 1);
        bus.btn_in = 1'b0;
        repeat (50) @(negedge clk);
        chk("rearm_low_held", bus.held, 0);
        chk("rearm_drain", sb.size(), 0);
        @(negedge clk);
        bus.btn_in = 1'b1;
        t0 = cyc;
        push(t0, 4, EV_PRESS);
        push(t0, 34, EV_RELEASE);
        push(t0, 84, EV_CLICK);
        repeat (30) @(negedge clk);
        bus.btn_in = 1'b0;
        repeat (120) @(negedge clk);
        chk("post_rst_drain", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
